// File: rtl/shift_pkg.sv
// Shared constants and types for the serial-to-parallel deserializer.
package shift_pkg;

   // Bit-order encoding carried on msb_first
   localparam logic MSB_FIRST = 1'b1;
   localparam logic LSB_FIRST = 1'b0;

   // Default assembled word width
   localparam int unsigned DefaultWidth = 8;

   // Deserializer state: StIdle when no bits are held, StShift mid-word
   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } deser_state_e;

endpackage

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with a one-word output buffer, selectable bit order,
// frame resync via clear and a sticky overrun flag for words dropped on a stalled consumer.
module shift_deserializer
   import shift_pkg::*;
#(
   parameter int unsigned N = DefaultWidth
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sin,
   input  logic         sin_valid,
   input  logic         msb_first,
   input  logic         clear,
   output logic [N-1:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         busy,
   output logic         overrun
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [CW-1:0] LastCnt = CW'(N - 1);

   deser_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  sr_q, sr_d;
   logic          order_q, order_d;
   logic [N-1:0]  dout_q, dout_d;
   logic          dout_valid_q, dout_valid_d;
   logic          ovr_q, ovr_d;

   logic          order_sel;
   logic [N-1:0]  sr_shifted;
   logic          word_done;

   // Order for the incoming bit: live input when starting a word, latched value otherwise
   always_comb begin
      order_sel  = (state_q == StIdle) ? msb_first : order_q;
      sr_shifted = (order_sel == MSB_FIRST) ? {sr_q[N-2:0], sin} : {sin, sr_q[N-1:1]};
      word_done  = sin_valid && !clear && (cnt_q == LastCnt);
   end

   // Next-state for the shift path and the output buffer
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      order_d      = order_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      ovr_d        = ovr_q;

      if (clear) begin
         // Resync drops the partial word but leaves the output buffer alone
         state_d = StIdle;
         cnt_d   = '0;
         sr_d    = '0;
         ovr_d   = 1'b0;
      end else if (sin_valid) begin
         sr_d = sr_shifted;
         if (state_q == StIdle) begin
            order_d = msb_first;
         end
         if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StIdle;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StShift;
         end
      end

      if (word_done) begin
         // A word may load if the buffer is free or being drained this same cycle
         if (!dout_valid_q || dout_ready) begin
            dout_d       = sr_shifted;
            dout_valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         sr_q         <= '0;
         order_q      <= MSB_FIRST;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         order_q      <= order_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         ovr_q        <= ovr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = (cnt_q != '0);
   assign overrun    = ovr_q;

endmodule
